fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage directly upstream of decode/control generation. It owns the fetch PC and issues single-outstanding reads to instruction memory. Each returned instruction goes into a DEPTH-entry FIFO together with its PC, a static branch prediction and a predicted target. The decode stage consumes these through a valid/ready handshake. A redirect from execute squashes all queued and in-flight work.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0060, first fetch address after reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- imem_address  out  32  fetch address; held stable while imem_read=1.
- imem_read  out  1  read request; held until imem_resp.
- imem_rdata  in  32  instruction word; valid when imem_resp=1.
- imem_resp  in  1  one-cycle response pulse.
- redirect  in  1  mispredict/flush from execute.
- redirect_pc  in  32  new fetch PC; sampled when redirect=1.
- dec_ready  in  1  decode accepts the head entry this cycle.
- dec_valid  out  1  FIFO non-empty.
- dec_pc  out  32  head PC.
- dec_instruction  out  32  head instruction.
- dec_pc_target  out  32  head predicted next PC.
- dec_prediction  out  1  head predicted-taken flag.

## Operation
- State: fetch_pc, FSM {IDLE, FETCH, DISCARD}, FIFO storage, rd_ptr, wr_ptr, count (0..DEPTH).
- imem_read = (state != IDLE).
- imem_address = fetch_pc in FETCH, and held_addr in DISCARD.
- **IDLE -> FETCH**: when count < DEPTH and redirect=0.
- **FETCH, imem_resp=1, redirect=0**:
  - push {fetch_pc, imem_rdata, target, pred}.
  - fetch_pc <= pred ? target : fetch_pc+4.
  - Stay in FETCH if count_next < DEPTH, otherwise go to IDLE.
- **Prediction**, computed combinationally from imem_rdata[6:0]:
  - 7'b1101111 (jal): pred=1, target = fetch_pc + sign-extended J-imm.
  - 7'b1100011 (branch): pred = imm sign bit (backward taken, forward not); target = fetch_pc + B-imm if pred, else fetch_pc+4.
  - All other opcodes, including jalr: pred=0, target = fetch_pc+4.
  - All adds are 32-bit modulo 2^32.
- **Pop**: on dec_valid && dec_ready && !redirect, advance rd_ptr.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- **Redirect**, which has priority over push and pop:
  - count, rd_ptr and wr_ptr are cleared to 0; fetch_pc <= redirect_pc.
  - In FETCH without imem_resp that cycle: held_addr <= fetch_pc and go to DISCARD. The read stays asserted at the old address until imem_resp, and the response data is dropped.
  - In FETCH with imem_resp the same cycle: the response is dropped and the FSM goes to FETCH.
  - In IDLE or DISCARD: go to FETCH (IDLE) or stay in DISCARD.
- **DISCARD, imem_resp=1**: nothing is pushed; go to FETCH, since the queue is empty.
- dec_pc, dec_instruction, dec_pc_target and dec_prediction are forced to 0 when dec_valid=0.

## Timing
- Reset values: fetch_pc=RESET_PC, state=IDLE, count=0, pointers=0, imem_read=0, dec_valid=0, all dec_* outputs 0.
- Reset asserted mid-transaction aborts immediately; the eventual memory response is not tracked.
- First request: the first edge after rst deasserts moves IDLE->FETCH, and imem_read=1 in the following cycle.
- Response-to-decode latency: an imem_resp in cycle t gives dec_valid=1 in cycle t+1.
- Throughput: 1 instruction/cycle with a 1-cycle memory. A new address appears the cycle after imem_resp.
- Full queue: no request is issued while count=DEPTH. A pop in cycle t returns the FSM to FETCH at edge t+1.
- Redirect in cycle t: the FIFO reads empty in cycle t+1. The first fetch of redirect_pc is in cycle t+1, or the cycle after the discarded response.

## Test plan
- **Reset**: hold rst=0 for 3 cycles -> imem_read=0, dec_valid=0. Release -> imem_read=1 with imem_address=0x60 one cycle after the first edge.
- **Sequential fetch**: 1-cycle memory returns 0x00100093, dec_ready=1 -> dec_pc sequence 0x60, 0x64, 0x68; dec_prediction=0; dec_pc_target = dec_pc+4.
- **Backward branch and forward jal**: 0xFE0008E3 at 0x70 -> pred=1, target=0x60, next imem_address=0x60. 0x0080006F at 0x60 -> pred=1, target=0x68.
- **Full queue**: dec_ready=0 -> after 4 responses imem_read=0 and count=4. A single dec_ready pulse pops entry 0x60, and fetch resumes at 0x70 the next cycle.
- **Redirect with read pending**: redirect to 0x200 while the 0x80 read is outstanding -> imem_address stays 0x80 until imem_resp; that data never appears (dec_valid=0); then imem_address=0x200.
- **Redirect coincident with response and pop**: redirect, imem_resp and dec_ready all in one cycle -> response dropped, count=0 next cycle, imem_address=0x200.

Source files
------------

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the instruction-memory request/response channel, the execute
//   redirect, and the decode valid/ready channel of the fetch queue.
//
//   Signals:
//     imem_address    fetch address (held stable while imem_read=1)
//     imem_read       read request, held until imem_resp
//     imem_rdata      instruction word, valid with imem_resp
//     imem_resp       one-cycle response pulse
//     redirect        flush from execute
//     redirect_pc     new fetch PC, sampled with redirect
//     dec_ready       decode accepts head entry
//     dec_valid       queue non-empty
//     dec_pc          head PC
//     dec_instruction head instruction
//     dec_pc_target   head predicted next PC
//     dec_prediction  head predicted-taken flag
//
//   Modports:
//     master : the fetch queue itself
//     slave  : memory / execute / decode environment
// ---------------------------------------------------------------------------
interface fetch_queue_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instruction;
    logic [31:0] dec_pc_target;
    logic        dec_prediction;

    modport master (
        output imem_address, imem_read,
        input  imem_rdata, imem_resp,
        input  redirect, redirect_pc,
        input  dec_ready,
        output dec_valid, dec_pc, dec_instruction, dec_pc_target, dec_prediction
    );

    modport slave (
        input  imem_address, imem_read,
        output imem_rdata, imem_resp,
        output redirect, redirect_pc,
        output dec_ready,
        input  dec_valid, dec_pc, dec_instruction, dec_pc_target, dec_prediction
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch stage. Owns the fetch PC, issues single-outstanding
//   reads to instruction memory, applies a static branch prediction to each
//   returned word and queues {pc, instruction, target, prediction} in a
//   DEPTH-entry FIFO for decode. A redirect flushes the queue and any
//   in-flight read.
//
//   Parameters:
//     DEPTH    FIFO entries (power of two, >= 2)
//     RESET_PC first fetch address after reset
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  fetch_queue_if.master (memory, redirect and decode channels)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic              clk,
    input  logic              rst,
    fetch_queue_if.master     bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] target;
        logic        pred;
    } entry_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        held_addr_q, held_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t             fifo_q [DEPTH];
    entry_t             fifo_d [DEPTH];

    logic [31:0]        pc_plus4;
    logic [31:0]        j_imm;
    logic [31:0]        b_imm;
    logic               pred;
    logic [31:0]        target;
    logic               push;
    logic               pop;
    logic               dec_valid;
    entry_t             head;

    // Static prediction: jal always taken, conditional branches taken only
    // when the offset is negative (loop back-edges). jalr is never predicted
    // because its target needs a register value.
    always_comb begin
        pc_plus4 = fetch_pc_q + 32'd4;
        j_imm    = {{11{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[19:12],
                    bus.imem_rdata[20], bus.imem_rdata[30:21], 1'b0};
        b_imm    = {{19{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[7],
                    bus.imem_rdata[30:25], bus.imem_rdata[11:8], 1'b0};
        pred     = 1'b0;
        target   = pc_plus4;
        case (bus.imem_rdata[6:0])
            OPC_JAL: begin
                pred   = 1'b1;
                target = fetch_pc_q + j_imm;
            end
            OPC_BRANCH: begin
                if (b_imm[31]) begin
                    pred   = 1'b1;
                    target = fetch_pc_q + b_imm;
                end
            end
            default: ;
        endcase
    end

    assign dec_valid = (count_q != '0);
    assign push      = (state_q == FETCH) && bus.imem_resp && !bus.redirect;
    assign pop       = dec_valid && bus.dec_ready && !bus.redirect;

    // Queue bookkeeping; redirect overrides both push and pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_d     = fifo_q;
        if (bus.redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = bus.redirect_pc;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = '{pc: fetch_pc_q, instr: bus.imem_rdata,
                                     target: target, pred: pred};
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = pred ? target : pc_plus4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Fetch FSM. Decisions use count_d so that a pop from a full queue
    // restarts fetching on the very next edge.
    always_comb begin
        state_d     = state_q;
        held_addr_d = held_addr_q;
        case (state_q)
            IDLE: begin
                if (count_d < DEPTH_C) state_d = FETCH;
            end
            FETCH: begin
                if (bus.redirect) begin
                    if (bus.imem_resp) begin
                        state_d = FETCH;
                    end else begin
                        // Keep the bus stable at the old address until the
                        // in-flight read completes, then throw its data away.
                        held_addr_d = fetch_pc_q;
                        state_d     = DISCARD;
                    end
                end else if (bus.imem_resp) begin
                    state_d = (count_d < DEPTH_C) ? FETCH : IDLE;
                end
            end
            DISCARD: begin
                if (bus.imem_resp) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            held_addr_q <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            held_addr_q <= held_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset: contents are masked until count covers them.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign head                = fifo_q[rd_ptr_q];
    assign bus.imem_read       = (state_q != IDLE);
    assign bus.imem_address    = (state_q == DISCARD) ? held_addr_q : fetch_pc_q;
    assign bus.dec_valid       = dec_valid;
    assign bus.dec_pc          = dec_valid ? head.pc     : 32'd0;
    assign bus.dec_instruction = dec_valid ? head.instr  : 32'd0;
    assign bus.dec_pc_target   = dec_valid ? head.target : 32'd0;
    assign bus.dec_prediction  = dec_valid ? head.pred   : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue (DEPTH=4, RESET_PC=0x60). Inputs change
//   1 time unit after each rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] BR   = 32'hFE00_08E3;
    localparam logic [31:0] JAL  = 32'h0080_006F;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0060)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] tgt,
                              input logic pred);
        check({tag, "_valid"}, {31'd0, bus.dec_valid}, 32'd1);
        check({tag, "_pc"},    bus.dec_pc, pc);
        check({tag, "_instr"}, bus.dec_instruction, instr);
        check({tag, "_tgt"},   bus.dec_pc_target, tgt);
        check({tag, "_pred"},  {31'd0, bus.dec_prediction}, {31'd0, pred});
    endtask

    initial begin
        rst             = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.imem_resp   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.dec_ready   = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_read",  {31'd0, bus.imem_read}, 32'd0);
        check("rst_valid", {31'd0, bus.dec_valid}, 32'd0);
        check("rst_pc",    bus.dec_pc, 32'd0);
        check("rst_pred",  {31'd0, bus.dec_prediction}, 32'd0);
        rst = 1'b1;
        step();
        check("first_read", {31'd0, bus.imem_read}, 32'd1);
        check("first_addr", bus.imem_address, 32'h60);

        // Sequential fetch with a 1-cycle memory and decode always ready
        bus.dec_ready  = 1'b1;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = ADDI;
        step();
        check_head("seq0", 32'h60, ADDI, 32'h64, 1'b0);
        check("seq0_addr", bus.imem_address, 32'h64);
        step();
        check_head("seq1", 32'h64, ADDI, 32'h68, 1'b0);
        step();
        check_head("seq2", 32'h68, ADDI, 32'h6C, 1'b0);
        step();
        check("seq3_pc",   bus.dec_pc, 32'h6C);
        check("seq3_addr", bus.imem_address, 32'h70);

        // Backward branch at 0x70 predicted taken to 0x60
        bus.imem_rdata = BR;
        step();
        check_head("br", 32'h70, BR, 32'h60, 1'b1);
        check("br_addr", bus.imem_address, 32'h60);

        // Forward jal at 0x60 to 0x68
        bus.imem_rdata = JAL;
        step();
        check_head("jal", 32'h60, JAL, 32'h68, 1'b1);
        check("jal_addr", bus.imem_address, 32'h68);

        // Redirect with response and pop in the same cycle (back to 0x60)
        bus.imem_rdata  = ADDI;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h60;
        step();
        bus.redirect = 1'b0;
        check("rd60_valid", {31'd0, bus.dec_valid}, 32'd0);
        check("rd60_pc",    bus.dec_pc, 32'd0);
        check("rd60_addr",  bus.imem_address, 32'h60);

        // Fill the queue with decode stalled
        bus.dec_ready = 1'b0;
        repeat (4) step();
        bus.imem_resp = 1'b0;
        check("full_read",  {31'd0, bus.imem_read}, 32'd0);
        check("full_count", {29'd0, dut.count_q}, 32'd4);
        check_head("full_head", 32'h60, ADDI, 32'h64, 1'b0);
        step();
        check("full_hold_read", {31'd0, bus.imem_read}, 32'd0);

        // One pop restarts fetch at 0x70 on the next edge
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        check("resume_read", {31'd0, bus.imem_read}, 32'd1);
        check("resume_addr", bus.imem_address, 32'h70);
        check("resume_pc",   bus.dec_pc, 32'h64);
        check("resume_count", {29'd0, dut.count_q}, 32'd3);

        // Stream 0x70..0x7C while popping, leaving the 0x80 read outstanding
        bus.dec_ready = 1'b1;
        bus.imem_resp = 1'b1;
        repeat (4) step();
        bus.imem_resp = 1'b0;
        check("pre_rd_pc",   bus.dec_pc, 32'h74);
        check("pre_rd_addr", bus.imem_address, 32'h80);

        // Redirect to 0x200 while the 0x80 read is pending
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0;
        check("disc_read",  {31'd0, bus.imem_read}, 32'd1);
        check("disc_addr",  bus.imem_address, 32'h80);
        check("disc_valid", {31'd0, bus.dec_valid}, 32'd0);
        step();
        check("disc_addr2",  bus.imem_address, 32'h80);
        check("disc_valid2", {31'd0, bus.dec_valid}, 32'd0);
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.imem_resp  = 1'b1;
        step();
        bus.imem_resp = 1'b0;
        check("disc_done_valid", {31'd0, bus.dec_valid}, 32'd0);
        check("disc_done_addr",  bus.imem_address, 32'h200);
        check("disc_done_read",  {31'd0, bus.imem_read}, 32'd1);

        // Redirect coincident with response and pop
        bus.dec_ready  = 1'b0;
        bus.imem_rdata = ADDI;
        bus.imem_resp  = 1'b1;
        step();
        check_head("pre_co", 32'h200, ADDI, 32'h204, 1'b0);
        check("pre_co_addr", bus.imem_address, 32'h204);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        bus.dec_ready   = 1'b1;
        step();
        bus.redirect  = 1'b0;
        bus.imem_resp = 1'b0;
        bus.dec_ready = 1'b0;
        check("co_valid", {31'd0, bus.dec_valid}, 32'd0);
        check("co_count", {29'd0, dut.count_q}, 32'd0);
        check("co_addr",  bus.imem_address, 32'h200);
        check("co_read",  {31'd0, bus.imem_read}, 32'd1);
        step();
        check("co_valid2", {31'd0, bus.dec_valid}, 32'd0);

        // Asynchronous reset mid-transaction takes effect without a clock edge
        rst = 1'b0;
        #1;
        check("async_read",  {31'd0, bus.imem_read}, 32'd0);
        check("async_valid", {31'd0, bus.dec_valid}, 32'd0);
        step();
        rst = 1'b1;
        step();
        check("rerst_read", {31'd0, bus.imem_read}, 32'd1);
        check("rerst_addr", bus.imem_address, 32'h60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
